// File: rtl/branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// branch_predictor_bht
//
// Fetch-stage branch predictor.
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. The lookup on PC_F is purely combinational, so the
//   predicted next PC is available in the same cycle. Resolution updates
//   from decode are written on the rising clock edge. Two free-running
//   performance counters track resolved branches and mispredictions.
//
// Ports
//   clk           in   1      clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   PC_F          in   32     current fetch PC
//   pred_target   out  32     predicted next fetch PC
//   pred_taken_F  out  1      BTB hit and counter predicts taken
//   upd_valid     in   1      resolved control-flow instruction this cycle
//   upd_pc        in   32     PC of the resolved instruction
//   upd_taken     in   1      actual direction (1 = taken)
//   upd_target    in   32     actual taken target
//   upd_mispred   in   1      resolution disagreed with the prediction
//   branch_cnt    out  CNT_W  number of upd_valid cycles (wraps)
//   mispred_cnt   out  CNT_W  number of upd_valid && upd_mispred cycles (wraps)
// ---------------------------------------------------------------------------
module branch_predictor_bht #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      PC_F,
    output logic [31:0]      pred_target,
    output logic             pred_taken_F,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_mispred,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    // Direction counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;

    // Table storage
    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];

    logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // -----------------------------------------------------------------------
    // Lookup: reads the registered table only, so an update landing on the
    // same entry this cycle becomes visible on the next cycle.
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx = PC_F[IDX_W+1:2];
    assign f_tag = PC_F[31:IDX_W+2];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign pred_taken_F = f_hit && ctr_q[f_idx][1];
    // Fall-through wraps naturally at 2**32.
    assign pred_target  = pred_taken_F ? target_q[f_idx] : (PC_F + 32'd4);

    // Byte-offset bits never take part in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC_F[1:0], upd_pc[1:0]};

    // -----------------------------------------------------------------------
    // Update path
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        // NOTE: every _d starts as a copy of its _q so no path through this
        // block leaves a signal unassigned, which would infer a latch.
        valid_d       = valid_q;
        tag_d         = tag_q;
        target_d      = target_q;
        ctr_d         = ctr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (upd_valid) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
            if (upd_mispred) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end

            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != 2'b11) begin
                        ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
                    end
                    target_d[u_idx] = upd_target;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Miss + taken replaces whatever occupied the slot.
                // Not-taken misses are never allocated.
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = upd_target;
                ctr_d[u_idx]    = CTR_ALLOC;
            end
        end
    end

    // NOTE: the table lives in flops and is reset as a whole, since valid and
    // the counter reset value are architecturally visible; an SRAM-style
    // array without reset would not meet that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_bht
//
// Self-checking bench for branch_predictor_bht (IDX_W=4, CNT_W=32).
// Directed scenarios plus a randomized run checked against a behavioural
// table model built from plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_branch_predictor_bht;

    localparam int IDX_W   = 4;
    localparam int CNT_W   = 32;
    localparam int ENTRIES = 16;

    logic             clk;
    logic             rst_n;
    logic [31:0]      PC_F;
    logic [31:0]      pred_target;
    logic             pred_taken_F;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic [31:0]      upd_target;
    logic             upd_mispred;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor_bht #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PC_F         (PC_F),
        .pred_target  (pred_target),
        .pred_taken_F (pred_taken_F),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_mispred  (upd_mispred),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural reference model ----------------
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];   // 0..3, taken iff >= 2
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        logic [32:0] seq;
        seq = {1'b0, pc} + 33'd4;
        return m_pred_taken(pc) ? m_target[m_index(pc)] : seq[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    task automatic model_update();
        int i;
        if (!upd_valid) return;
        m_bcnt = m_bcnt + 32'd1;
        if (upd_mispred) m_mcnt = m_mcnt + 32'd1;
        i = m_index(upd_pc);
        if (m_hit(upd_pc)) begin
            if (upd_taken) begin
                m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_target[i] = upd_target;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (upd_taken) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = m_tagof(upd_pc);
            m_target[i] = upd_target;
            m_ctr[i]    = 2;
        end
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic mp);
        upd_valid   = v;
        upd_pc      = pc;
        upd_taken   = tk;
        upd_target  = tgt;
        upd_mispred = mp;
    endtask

    task automatic idle();
        set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Advance one clock; model commits with the inputs seen at the edge.
    // Returns 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
    endtask

    // Asserts reset (1 unit after an edge), leaves it low 2 units so the
    // caller can inspect the async effect, then releases on a negedge.
    task automatic reset_assert();
        rst_n = 1'b0;
        #2;
        model_reset();
    endtask

    task automatic reset_release();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        PC_F = 32'h100;
        reset_assert();
        reset_release();
        #1;
        n_checks++;
        if (pred_taken_F !== 1'b0) begin
            n_fail++; $display("FAIL reset_taken got %b exp 0", pred_taken_F);
        end
        n_checks++;
        if (pred_target !== 32'h104) begin
            n_fail++; $display("FAIL reset_target got %h exp 00000104", pred_target);
        end
        n_checks++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters got %0d/%0d exp 0/0", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_training();
        PC_F = 32'h100;
        set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
        tick(); idle(); #1;
        n_checks++;
        if (pred_taken_F !== 1'b1 || pred_target !== 32'h200) begin
            n_fail++; $display("FAIL train_alloc got %b/%h exp 1/00000200", pred_taken_F, pred_target);
        end
        // weak-T -> weak-NT
        set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        tick(); idle(); #1;
        n_checks++;
        if (pred_taken_F !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++; $display("FAIL train_dec got %b/%h exp 0/00000104", pred_taken_F, pred_target);
        end
        // two taken -> strong-T, third taken must saturate
        set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        tick(); tick(); idle(); #1;
        n_checks++;
        if (pred_target !== 32'h200) begin
            n_fail++; $display("FAIL train_inc got %h exp 00000200", pred_target);
        end
        set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        tick();
        set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        tick(); idle(); #1;
        // 11 -> 11 -> 10: still predicts taken only if the counter saturated
        n_checks++;
        if (pred_taken_F !== 1'b1 || pred_target !== 32'h200) begin
            n_fail++; $display("FAIL train_saturate got %b/%h exp 1/00000200", pred_taken_F, pred_target);
        end
        // strong-NT floor: drive down many times, then one taken -> 01, still NT
        set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        repeat (5) tick();
        set_upd(1'b1, 32'h100, 1'b1, 32'h300, 1'b0);
        tick(); idle(); #1;
        n_checks++;
        if (pred_taken_F !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++; $display("FAIL train_floor got %b/%h exp 0/00000104", pred_taken_F, pred_target);
        end
    endtask

    task automatic test_alias();
        reset_assert();
        reset_release();
        set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        tick();
        set_upd(1'b1, 32'h140, 1'b1, 32'h500, 1'b0);
        tick(); idle();
        PC_F = 32'h140; #1;
        n_checks++;
        if (pred_taken_F !== 1'b1 || pred_target !== 32'h500) begin
            n_fail++; $display("FAIL alias_new_hit got %b/%h exp 1/00000500", pred_taken_F, pred_target);
        end
        PC_F = 32'h100; #1;
        n_checks++;
        if (pred_taken_F !== 1'b0 || pred_target !== 32'h104) begin
            n_fail++; $display("FAIL alias_old_miss got %b/%h exp 0/00000104", pred_taken_F, pred_target);
        end
        set_upd(1'b1, 32'h180, 1'b0, 32'h0, 1'b0);
        tick(); idle();
        PC_F = 32'h140; #1;
        n_checks++;
        if (pred_taken_F !== 1'b1 || pred_target !== 32'h500) begin
            n_fail++; $display("FAIL alias_nt_no_alloc got %b/%h exp 1/00000500", pred_taken_F, pred_target);
        end
        // low address bits ignored
        PC_F = 32'h143; #1;
        n_checks++;
        if (pred_target !== 32'h500) begin
            n_fail++; $display("FAIL alias_low_bits got %h exp 00000500", pred_target);
        end
    endtask

    task automatic test_same_cycle();
        reset_assert();
        reset_release();
        PC_F = 32'h100;
        set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
        #1;
        n_checks++;
        if (pred_target !== 32'h104) begin
            n_fail++; $display("FAIL same_cycle_old got %h exp 00000104", pred_target);
        end
        tick(); idle(); #1;
        n_checks++;
        if (pred_target !== 32'h200) begin
            n_fail++; $display("FAIL same_cycle_new got %h exp 00000200", pred_target);
        end
        PC_F = 32'hFFFF_FFFC; #1;
        n_checks++;
        if (pred_taken_F !== 1'b0 || pred_target !== 32'h0) begin
            n_fail++; $display("FAIL wrap_target got %b/%h exp 0/00000000", pred_taken_F, pred_target);
        end
    endtask

    task automatic test_perf_counters();
        reset_assert();
        reset_release();
        set_upd(1'b1, 32'h300, 1'b1, 32'h700, 1'b1); tick();
        set_upd(1'b1, 32'h300, 1'b1, 32'h700, 1'b0); tick();
        set_upd(1'b0, 32'h300, 1'b1, 32'h700, 1'b1); tick();
        set_upd(1'b1, 32'h400, 1'b0, 32'h0,   1'b0); tick();
        set_upd(1'b1, 32'h300, 1'b1, 32'h700, 1'b1); tick();
        set_upd(1'b1, 32'h400, 1'b0, 32'h0,   1'b0); tick();
        idle();
        PC_F = 32'h300; #1;
        n_checks++;
        if (branch_cnt !== 32'd5) begin
            n_fail++; $display("FAIL perf_branch got %0d exp 5", branch_cnt);
        end
        n_checks++;
        if (mispred_cnt !== 32'd2) begin
            n_fail++; $display("FAIL perf_mispred got %0d exp 2", mispred_cnt);
        end
        n_checks++;
        if (pred_target !== 32'h700) begin
            n_fail++; $display("FAIL perf_trained got %h exp 00000700", pred_target);
        end
        // async reset mid-sequence, with an update pending
        set_upd(1'b1, 32'h300, 1'b1, 32'h900, 1'b1);
        reset_assert();
        n_checks++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            n_fail++; $display("FAIL perf_reset_cnt got %0d/%0d exp 0/0", branch_cnt, mispred_cnt);
        end
        n_checks++;
        if (pred_taken_F !== 1'b0 || pred_target !== 32'h304) begin
            n_fail++; $display("FAIL perf_reset_miss got %b/%h exp 0/00000304", pred_taken_F, pred_target);
        end
        reset_release();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
        // few tags and all indices -> frequent hits and aliasing
        pc = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
        return pc;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            PC_F = rand_pc();
            set_upd($urandom_range(0, 3) != 0, rand_pc(), $urandom_range(0, 2) != 0,
                    $urandom, $urandom_range(0, 1) == 1);
            #1;
            n_checks++;
            if (pred_taken_F !== m_pred_taken(PC_F) || pred_target !== m_pred_target(PC_F)) begin
                n_fail++;
                $display("FAIL random_lookup pc=%h got %b/%h exp %b/%h", PC_F,
                         pred_taken_F, pred_target, m_pred_taken(PC_F), m_pred_target(PC_F));
            end
            n_checks++;
            if (branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin
                n_fail++;
                $display("FAIL random_counters got %0d/%0d exp %0d/%0d",
                         branch_cnt, mispred_cnt, m_bcnt, m_mcnt);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        PC_F  = 32'h0;
        idle();
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_training();
        test_alias();
        test_same_cycle();
        test_perf_counters();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
